// File: rtl/mmio_uart_tx_if.sv
// CPU data-store bus as seen by memory-mapped peripherals.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [3:0]  sel;

    modport master (output memwrite, dataadr, writedata, sel);
    modport slave  (input  memwrite, dataadr, writedata, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte stores to UART_ADDR are queued and sent as 8N1 frames.
// Define UART_PARITY_EN to insert an even-parity bit (8E1).
module mmio_uart_tx #(
    parameter logic [31:0] UART_ADDR    = 32'h0000_FF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic [7:0]           drop_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state, w_state_next;
    logic [BW-1:0]   r_baud, w_baud_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_tx, w_tx_next;
    logic            r_busy;
    logic            w_pop;
    logic            w_baud_done;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_full, r_empty;
    logic [7:0]      r_drop;
    logic            w_push, w_push_ok, w_drop;
    logic [7:0]      w_lane;
    logic [7:0]      w_head;

`ifdef UART_PARITY_EN
    logic            r_parity;
`endif

    assign w_push    = bus.memwrite && (bus.dataadr == UART_ADDR) && (bus.sel != '0);
    assign w_push_ok = w_push && (r_count != FULL_CNT);
    assign w_drop    = w_push && (r_count == FULL_CNT);
    assign w_head    = r_mem[r_rptr];

    // Lowest enabled byte lane wins when several are set.
    always_comb begin
        w_lane = bus.writedata[7:0];
        if (bus.sel[0])      w_lane = bus.writedata[7:0];
        else if (bus.sel[1]) w_lane = bus.writedata[15:8];
        else if (bus.sel[2]) w_lane = bus.writedata[23:16];
        else if (bus.sel[3]) w_lane = bus.writedata[31:24];
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop)      w_count_next = r_count + CW'(1);
        else if (!w_push_ok && w_pop) w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= w_lane;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_drop  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 8'd1;
        end
    end

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_parity <= 1'b0;
        else if (w_pop) r_parity <= ^w_head;
    end
`endif

    // tx is registered from the next state so the line changes on the same edge as the state.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign drop_cnt   = r_drop;
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-store bus, downstream of the CPU top level.
- Consumes the same memwrite / dataadr / writedata / sel outputs that feed the data memory.
- Captures byte stores to one fixed address, buffers them in a small FIFO, and serialises them on a single tx line as 8N1 frames, LSB first.
- Gives the CPU stores a console output without stalling the pipeline.

Parameters:
- UART_ADDR, 32'h0000_FF00, byte address of the TX data register; must be word-aligned.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- memwrite  input  1  CPU store strobe.
- dataadr  input  32  CPU store address.
- writedata  input  32  CPU store data.
- sel  input  4  byte-lane enables of the store.
- tx  output  1  serial output; idles high.
- busy  output  1  high while a frame is being shifted out.
- fifo_full  output  1  FIFO occupancy equals FIFO_DEPTH.
- fifo_empty  output  1  FIFO occupancy is zero.
- drop_cnt  output  8  number of stores discarded because the FIFO was full; saturates at 255.

Behaviour:
- Reset, asynchronous: tx=1, busy=0, fifo_empty=1, fifo_full=0, drop_cnt=0, FIFO pointers and count=0, FSM=IDLE, bit and baud counters=0.
- Push qualifier: memwrite && dataadr==UART_ADDR && sel!=0, sampled at the rising edge.
  - Byte lane pushed is the lowest set bit of sel: sel[0] selects writedata[7:0], sel[1] selects [15:8], and so on.
  - Every qualifying cycle is one push; there is no edge detection.
- Full decision: uses the count registered before the edge.
  - A push while full is dropped and drop_cnt increments (saturating), even if a pop happens in the same cycle.
  - A push while not full is stored.
  - Simultaneous push and pop when not full leaves the count unchanged.
- Non-matching addresses are ignored entirely.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START. Busy rises on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE is occupied for exactly one cycle between the end of STOP and the next START.
- Frame length: 10*CLKS_PER_BIT cycles of START through STOP, plus 1 IDLE cycle.
- Latency: push at edge N into an empty FIFO with the FSM idle gives the pop at edge N+1, and tx=0 is visible from edge N+1.
- tx, busy, fifo_full, fifo_empty and drop_cnt are all registered outputs, with no combinational path from the inputs.
- Pointer and count arithmetic:
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - The count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-frame: tx returns high immediately, the FIFO contents are discarded, and the partial frame is not resumed.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - The frame becomes 11*CLKS_PER_BIT cycles, 8E1.
- When undefined: no PARITY state exists, frames are 8N1, and no parity logic is synthesised.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset check: assert rst mid-frame -> tx=1, busy=0, fifo_empty=1 and drop_cnt=0 asynchronously, with no further transitions after release.
- Single byte: store 0x00000055 to 0x0000FF00 with sel=0001 -> tx low from the next edge for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4; busy is high for 40 cycles.
- Lane select: store 0xA5000000 with sel=1000 -> transmitted byte 0xA5. A store to 0x0000FF04, or with sel=0000 -> no push, fifo_empty stays 1.
- Overflow: 10 consecutive qualifying stores while idle:
  - The first byte is popped one edge after its push, so the FIFO holds 8 after 9 stores.
  - The 10th store is dropped -> drop_cnt=1, fifo_full=1.
  - The first 9 bytes are serialised in order, with exactly 1 idle cycle between frames.
- Saturation: 300 stores while full -> drop_cnt=255.
- Parity (UART_PARITY_EN defined): byte 0x07 -> parity bit 1 between bit 7 and stop; frame length 44 cycles. Byte 0x03 -> parity bit 0.
